enc_speed_error: RTL and testbench
==================================

// Module: enc_speed_error
// PURPOSE
//  Quadrature-encoder front end for the PID speed loop. Decodes motor encoder A/B, counts
//  signed edges over a fixed sample window and latches speed = counts/window. Produces
//  e_out = setpoint - speed with a one-cycle e_valid strobe; e_out drives the PID's e_in.
// PARAMETERS
//  SAMPLE_CLKS  1000  clocks per speed sample window (>=4)
//  W            16    width of setpoint/speed/e_out (two's complement)
// PORTS
//  clk       in   1  system clock
//  reset     in   1  asynchronous, active-high reset
//  enc_a     in   1  encoder channel A (asynchronous to clk)
//  enc_b     in   1  encoder channel B (asynchronous to clk)
//  setpoint  in   W  signed target speed, counts per window; sampled at window end
//  err_clr   in   1  clears enc_err
//  speed     out  W  signed counts measured in the last completed window
//  e_out     out  W  signed saturated error, setpoint - speed
//  e_valid   out  1  one-cycle pulse: speed/e_out updated
//  enc_err   out  1  sticky illegal-transition flag
// BEHAVIOUR
//  - Reset (async assert, sync deassert by design): speed=0, e_out=0, e_valid=0,
//    enc_err=0; accumulator, window timer and sync flops cleared; armed=0.
//  - A/B pass through a 2-flop synchronizer; pin-to-decode latency is 2 clk.
//  - Decode on synced {A,B} vs. prev: 00->10->11->01->00 = +1, reverse order = -1,
//    unchanged = 0, both bits changed = illegal (no count, enc_err<=1).
//  - armed: first decode cycle after reset only loads prev; no count, no enc_err.
//  - Accumulator W bits signed, saturating at +(2^(W-1)-1) / -2^(W-1) (no wrap).
//  - Timer counts 0..SAMPLE_CLKS-1, wraps to 0. Terminal cycle: speed<=acc+step (edge
//    in terminal cycle counts in this window), acc<=0, e_out<=sat(setpoint-(acc+step))
//    computed in W+1 bits then clamped to W; e_valid high for the following cycle only.
//  - First e_valid occurs SAMPLE_CLKS cycles after reset release; then every SAMPLE_CLKS.
//  - enc_err: set on illegal transition; cleared by err_clr; simultaneous set and clear:
//    set wins.
//  - setpoint changes mid-window have no effect until the next terminal cycle.
//  - Reset mid-window discards the partial count; no e_valid for the aborted window.
// CONFIGURATION
//  ENC_FILTER_EN defined: after synchronizer, each channel passes a 3-sample majority-free
//  debounce: filtered value updates only after 3 consecutive equal synced samples; pin-to-
//  decode latency 5 clk; pulses <3 clk are ignored. Undefined: no filter, latency 2 clk,
//  every synced change is decoded.
// TESTING
//  1 Reset, SAMPLE_CLKS=100, setpoint=0, A/B static -> e_valid every 100 clk, speed=0,
//    e_out=0, enc_err=0.
//  2 10 forward quadrature steps (10 clk apart) in one window, setpoint=25 -> speed=10,
//    e_out=15 at next e_valid; following idle window -> speed=0, e_out=25.
//  3 5 reverse steps, setpoint=32767 -> speed=-5, e_out=32767 (clamped, no wrap).
//  4 A and B toggle same clk from 00 to 11 -> enc_err=1, count unchanged; err_clr pulse
//    -> enc_err=0; err_clr coincident with new illegal step -> enc_err stays 1.
//  5 Hold A/B=11, pulse reset mid-window -> all outputs 0, no count/enc_err from the 11
//    level, first e_valid exactly SAMPLE_CLKS clk after release.
//  6 2-clk glitch on A -> with ENC_FILTER_EN: speed=0; without: +1 then -1, speed=0 if in
//    same window, enc_err=0 in both builds.

Source files
------------

// File: rtl/enc_speed_error.sv
//============================================================================
// Module  : enc_speed_error
// Purpose : Quadrature decode, windowed signed speed count and saturated
//           speed error (setpoint - speed) for the PID speed loop.
// Options : ENC_FILTER_EN - 3-sample debounce per channel after the synchronizer
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module enc_speed_error #(
  parameter int SAMPLE_CLKS = 1000,
  parameter int W           = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enc_a,
  input  logic                enc_b,
  input  logic signed [W-1:0] setpoint,
  input  logic                err_clr,
  output logic signed [W-1:0] speed,
  output logic signed [W-1:0] e_out,
  output logic                e_valid,
  output logic                enc_err
);

  localparam int               c_tmr_w = (SAMPLE_CLKS > 1) ? $clog2(SAMPLE_CLKS) : 1;
  localparam logic [c_tmr_w-1:0] c_last = c_tmr_w'(SAMPLE_CLKS - 1);

  // Clamp a W+1 bit signed value into W bits (overflow when the top two bits differ).
  function automatic logic signed [W-1:0] sat(input logic signed [W:0] v);
    if (v[W] != v[W-1])
      return v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      return v[W-1:0];
  endfunction

  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] w_cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {enc_a, enc_b};
      r_sync2 <= r_sync1;
    end
  end

`ifdef ENC_FILTER_EN
  // Decode starts once the first post-reset pin level has crossed sync + filter.
  localparam logic [2:0] c_fill = 3'd6;

  logic [1:0] r_hist1;
  logic [1:0] r_hist2;
  logic [1:0] r_filt;
  logic [1:0] w_stable;

  assign w_stable = ~(r_sync2 ^ r_hist1) & ~(r_hist1 ^ r_hist2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist1 <= '0;
      r_hist2 <= '0;
      r_filt  <= '0;
    end else begin
      r_hist1 <= r_sync2;
      r_hist2 <= r_hist1;
      r_filt  <= (w_stable & r_sync2) | (~w_stable & r_filt);
    end
  end

  assign w_cur = r_filt;
`else
  // Decode starts once the first post-reset pin level has crossed the synchronizer.
  localparam logic [2:0] c_fill = 3'd3;

  assign w_cur = r_sync2;
`endif

  logic [1:0]          r_prev;
  logic [2:0]          r_fill;
  logic [c_tmr_w-1:0]  r_tmr;
  logic signed [W-1:0] r_acc;

  logic                w_armed;
  logic                w_up;
  logic                w_dn;
  logic                w_illegal;
  logic                w_term;
  logic signed [W:0]   w_step;
  logic signed [W:0]   w_acc_sum;
  logic signed [W-1:0] w_acc_nx;
  logic signed [W:0]   w_diff;

  assign w_armed = (r_fill == c_fill);
  assign w_term  = (r_tmr == c_last);

  always_comb begin
    w_up      = 1'b0;
    w_dn      = 1'b0;
    w_illegal = 1'b0;
    if (w_armed) begin
      case ({r_prev, w_cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_up = 1'b1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_dn = 1'b1;
        default:                                w_illegal = ((r_prev ^ w_cur) == 2'b11);
      endcase
    end
  end

  assign w_step    = w_up ? (W+1)'(1) : (w_dn ? {(W+1){1'b1}} : '0);
  assign w_acc_sum = {r_acc[W-1], r_acc} + w_step;
  assign w_acc_nx  = sat(w_acc_sum);
  assign w_diff    = {setpoint[W-1], setpoint} - {w_acc_nx[W-1], w_acc_nx};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev  <= '0;
      r_fill  <= '0;
      r_tmr   <= '0;
      r_acc   <= '0;
      speed   <= '0;
      e_out   <= '0;
      e_valid <= 1'b0;
      enc_err <= 1'b0;
    end else begin
      r_prev  <= w_cur;
      if (!w_armed)
        r_fill <= r_fill + 3'd1;

      e_valid <= w_term;
      if (w_term) begin
        r_tmr <= '0;
        r_acc <= '0;
        speed <= w_acc_nx;
        e_out <= sat(w_diff);
      end else begin
        r_tmr <= r_tmr + 1'b1;
        r_acc <= w_acc_nx;
      end

      if (w_illegal)
        enc_err <= 1'b1;
      else if (err_clr)
        enc_err <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_enc_speed_error.sv
//============================================================================
// Module  : tb_enc_speed_error
// Purpose : Directed + randomized bench for enc_speed_error against an
//           edge-history reference model (honours ENC_FILTER_EN).
// Rev     : 1.0  initial release
//============================================================================
`default_nettype none

module tb_enc_speed_error;

  localparam int S = 100;
  localparam int W = 16;
`ifdef ENC_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enc_a = 1'b0;
  logic                enc_b = 1'b0;
  logic                err_clr = 1'b0;
  logic signed [W-1:0] setpoint = '0;
  logic signed [W-1:0] speed;
  logic signed [W-1:0] e_out;
  logic                e_valid;
  logic                enc_err;

  int errors = 0;
  int checks = 0;
  int pos    = 0;

  always #5 clk = ~clk;

  enc_speed_error #(.SAMPLE_CLKS(S), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .setpoint (setpoint),
    .err_clr  (err_clr),
    .speed    (speed),
    .e_out    (e_out),
    .e_valid  (e_valid),
    .enc_err  (enc_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // Position on the quadrature cycle 00 -> 10 -> 11 -> 01.
  function automatic int ph(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] pins(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  task automatic set_pos(input int p);
    pos = p;
    {enc_a, enc_b} = pins(p);
  endtask

  // ---------------- reference model ----------------
  logic [1:0] mh [0:4];   // pin level at this edge ([0]) and the four before it
  logic [1:0] mfilt;
  logic [1:0] mprev;
  int         mn, macc, mspeed, meout;
  bit         mvalid, merr;

  always @(posedge clk) begin : p_model
    logic [1:0] cur;
    int         d, step;
    bit         ill;
    if (reset) begin
      for (int k = 0; k < 5; k++) mh[k] = 2'b00;
      mfilt = 2'b00; mprev = 2'b00;
      mn = 0; macc = 0; mspeed = 0; meout = 0; mvalid = 0; merr = 0;
    end else begin
      mn++;
      for (int k = 4; k > 0; k--) mh[k] = mh[k-1];
      mh[0] = {enc_a, enc_b};
`ifdef ENC_FILTER_EN
      cur = mfilt;
      for (int i = 0; i < 2; i++)
        if (mh[2][i] == mh[3][i] && mh[3][i] == mh[4][i]) mfilt[i] = mh[2][i];
`else
      cur = mh[2];
`endif
      step = 0; ill = 0;
      if (mn > LAT) begin
        d    = (ph(cur) - ph(mprev) + 4) % 4;
        step = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
        ill  = (d == 2);
      end
      mprev = cur;
      macc  = sat(macc + step);
      if (mn % S == 0) begin
        mspeed = macc;
        meout  = sat(int'(setpoint) - macc);
        macc   = 0;
        mvalid = 1;
      end else begin
        mvalid = 0;
      end
      if (ill)          merr = 1;
      else if (err_clr) merr = 0;
    end
  end

  always @(posedge clk) begin : p_compare
    #1;
    chk("speed",   int'(speed),   mspeed);
    chk("e_out",   int'(e_out),   meout);
    chk("e_valid", int'(e_valid), int'(mvalid));
    chk("enc_err", int'(enc_err), int'(merr));
  end

  // Cycles until the next e_valid, bounded; a timeout counts as a failed check.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (!e_valid && cyc < 3*S);
    if (!e_valid) chk("e_valid_timeout", cyc, -1);
  endtask

  initial begin
    int cyc, r, v, hold;

    // 1: reset and idle windows
    repeat (3) @(negedge clk);
    chk("rst_speed",   int'(speed),   0);
    chk("rst_e_out",   int'(e_out),   0);
    chk("rst_e_valid", int'(e_valid), 0);
    chk("rst_enc_err", int'(enc_err), 0);
    reset = 1'b0;
    wait_valid(cyc);
    chk("first_valid_delay", cyc, S);
    wait_valid(cyc);
    chk("valid_period", cyc, S);
    chk("idle_speed", int'(speed), 0);
    chk("idle_e_out", int'(e_out), 0);

    // 2: ten forward steps, setpoint 25
    setpoint = 16'sd25;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); set_pos(pos + 1);
      repeat (9) @(negedge clk);
    end
    wait_valid(cyc);
    chk("fwd_speed", int'(speed), 10);
    chk("fwd_e_out", int'(e_out), 15);
    wait_valid(cyc);
    chk("fwd_idle_speed", int'(speed), 0);
    chk("fwd_idle_e_out", int'(e_out), 25);

    // 3: five reverse steps, setpoint at positive limit
    setpoint = 16'sd32767;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); set_pos(pos - 1);
      repeat (9) @(negedge clk);
    end
    wait_valid(cyc);
    chk("rev_speed", int'(speed), -5);
    chk("rev_e_out_clamp", int'(e_out), 32767);

    // 4: illegal transitions and err_clr priority
    @(negedge clk); set_pos(pos + 2);
    repeat (10) @(negedge clk);
    chk("illegal_sets_err", int'(enc_err), 1);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("err_clr_clears", int'(enc_err), 0);
    repeat (5) @(negedge clk);
    set_pos(pos + 2);
    repeat (LAT - 1) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    chk("set_beats_clear", int'(enc_err), 1);
    wait_valid(cyc);
    chk("illegal_no_count", int'(speed), 0);

    // 5: reset mid-window with A/B held at 11
    @(negedge clk); set_pos(pos + 1);
    repeat (30) @(negedge clk);
    reset = 1'b1; #1;
    chk("midrst_speed",   int'(speed),   0);
    chk("midrst_e_out",   int'(e_out),   0);
    chk("midrst_enc_err", int'(enc_err), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_valid(cyc);
    chk("midrst_valid_delay", cyc, S);
    chk("midrst_speed_after", int'(speed), 0);
    chk("midrst_err_after", int'(enc_err), 0);

    // 6: 2-clk glitch on A from 00
    @(negedge clk); set_pos(pos - 1);
    repeat (10) @(negedge clk); set_pos(pos - 1);
    wait_valid(cyc);
    @(negedge clk); enc_a = 1'b1;
    repeat (2) @(negedge clk); enc_a = 1'b0;
    wait_valid(cyc);
    chk("glitch_speed", int'(speed), 0);
    chk("glitch_err",   int'(enc_err), 0);

    // random walk: fast changes first, then edges held >= 4 clk
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = 1'b0;
      hold++;
      if (c < 1500 || hold >= 4) begin
        r = $urandom_range(0, 99);
        if (r < 10)      begin set_pos(pos + 1); hold = 0; end
        else if (r < 20) begin set_pos(pos - 1); hold = 0; end
        else if (r < 22) begin set_pos(pos + 2); hold = 0; end
      end
      err_clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 3))
          0:       setpoint = 16'sd32767;
          1:       setpoint = -16'sd32768;
          2:       begin v = $urandom_range(0, 200); setpoint = 16'(v - 100); end
          default: setpoint = 16'($urandom);
        endcase
      end
      if ($urandom_range(0, 799) == 0) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0; err_clr = 1'b0;
    repeat (2*S) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
